// File: rtl/fetch_unit.sv
// Instruction fetch stage: three-state FSM driving a 6-bit PC into a
// combinational instruction memory and registering the word for decode.
module fetch_unit #(
    parameter logic [5:0]  RESET_PC  = 6'd0,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [5:0]  branch_target,
    output logic [5:0]  imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic [5:0]  pc_out,
    output logic        instr_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  pc_q;
    logic [5:0]  pc_d;
    logic [15:0] instr_d;
    logic [5:0]  pc_out_d;
    logic        valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            instr_out   <= 16'h0000;
            pc_out      <= 6'd0;
            instr_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_out   <= instr_d;
            pc_out      <= pc_out_d;
            instr_valid <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_out;
        pc_out_d = pc_out;
        valid_d  = instr_valid;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                end
            end
            FETCH: begin
                // a redirect wins even over a stalled downstream
                if (branch_taken) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    if (imem_data == HALT_WORD) begin
                        state_d = HALTED;
                        valid_d = 1'b0;
                    end else begin
                        instr_d  = imem_data;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + 6'd1;
                    end
                end
            end
            HALTED: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = RESET_PC;
                valid_d = 1'b0;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instruction memory
// and hand-computed expected values.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [5:0]  branch_target;
    logic [5:0]  imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic [5:0]  pc_out;
    logic        instr_valid;
    logic        halted;

    logic [15:0] mem [64];
    int n_chk;
    int n_err;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .halted       (halted)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] ins,
                           input logic [5:0] pc, input logic v,
                           input logic [5:0] addr);
        chk({tag, ".instr"}, instr_out, ins);
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".valid"}, instr_valid, v);
        chk({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'h4241;
        mem[1] = 16'hEC7F;
        mem[2] = 16'h4205;
        mem[5] = 16'hFFFF;

        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 6'd0;
        #1;
        chk_out("rst", 16'h0000, 6'd0, 1'b0, 6'd0);
        chk("rst.halted", halted, 1'b0);
        step();
        step();
        rst_n = 1'b1;

        step();
        chk_out("idle", 16'h0000, 6'd0, 1'b0, 6'd0);

        start = 1'b1;
        step();
        start = 1'b0;
        chk_out("start", 16'h0000, 6'd0, 1'b0, 6'd0);
        step();
        chk_out("f0", 16'h4241, 6'd0, 1'b1, 6'd1);
        step();
        chk_out("f1", 16'hEC7F, 6'd1, 1'b1, 6'd2);
        step();
        chk_out("f2", 16'h4205, 6'd2, 1'b1, 6'd3);
        step();
        chk_out("f3", 16'h1003, 6'd3, 1'b1, 6'd4);
        step();
        chk_out("f4", 16'h1004, 6'd4, 1'b1, 6'd5);
        chk("f4.halted", halted, 1'b0);

        step();
        chk_out("halt", 16'h1004, 6'd4, 1'b0, 6'd5);
        chk("halt.halted", halted, 1'b1);
        branch_taken = 1'b1;
        branch_target = 6'd20;
        stall = 1'b1;
        step();
        branch_taken = 1'b0;
        stall = 1'b0;
        chk_out("halt_ign", 16'h1004, 6'd4, 1'b0, 6'd5);
        chk("halt_ign.halted", halted, 1'b1);

        start = 1'b1;
        step();
        start = 1'b0;
        chk_out("restart", 16'h1004, 6'd4, 1'b0, 6'd0);
        chk("restart.halted", halted, 1'b0);
        step();
        chk_out("r0", 16'h4241, 6'd0, 1'b1, 6'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_out("r1", 16'hEC7F, 6'd1, 1'b1, 6'd2);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", 16'hEC7F, 6'd1, 1'b1, 6'd2);
        end
        stall = 1'b0;
        step();
        chk_out("resume", 16'h4205, 6'd2, 1'b1, 6'd3);

        branch_taken = 1'b1;
        branch_target = 6'd7;
        step();
        branch_taken = 1'b0;
        chk_out("br7", 16'h4205, 6'd2, 1'b0, 6'd7);
        step();
        chk_out("f7", 16'h1007, 6'd7, 1'b1, 6'd8);

        branch_taken = 1'b1;
        branch_target = 6'd3;
        stall = 1'b1;
        step();
        branch_taken = 1'b0;
        stall = 1'b0;
        chk_out("br3", 16'h1007, 6'd7, 1'b0, 6'd3);
        step();
        chk_out("b3", 16'h1003, 6'd3, 1'b1, 6'd4);

        branch_taken = 1'b1;
        branch_target = 6'd62;
        step();
        branch_taken = 1'b0;
        chk_out("br62", 16'h1003, 6'd3, 1'b0, 6'd62);
        step();
        chk_out("w62", 16'h103E, 6'd62, 1'b1, 6'd63);
        step();
        chk_out("w63", 16'h103F, 6'd63, 1'b1, 6'd0);
        step();
        chk_out("w0", 16'h4241, 6'd0, 1'b1, 6'd1);
        step();
        chk_out("w1", 16'hEC7F, 6'd1, 1'b1, 6'd2);

        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 16'h0000, 6'd0, 1'b0, 6'd0);
        chk("arst.halted", halted, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk_out("post0", 16'h0000, 6'd0, 1'b0, 6'd0);
        step();
        chk_out("post1", 16'h0000, 6'd0, 1'b0, 6'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk_out("post_f0", 16'h4241, 6'd0, 1'b1, 6'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 6'd0, which sets the program-counter value loaded on reset and on restart.
REQ-002 The block SHALL have parameter HALT_WORD, default 16'hFFFF, which is the instruction encoding that stops fetching.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: pulse that leaves IDLE or HALTED and begins fetching at RESET_PC.
REQ-006 Port stall, input, 1 bit: downstream not ready; hold all fetch state.
REQ-007 Port branch_taken, input, 1 bit: redirect request from the execute stage.
REQ-008 Port branch_target, input, 6 bits: redirect address, used when branch_taken=1.
REQ-009 Port imem_addr, output, 6 bits: read address to the instruction memory; equals the internal PC.
REQ-010 Port imem_data, input, 16 bits: combinational instruction memory read data for imem_addr.
REQ-011 Port instr_out, output, 16 bits: registered instruction to decode.
REQ-012 Port pc_out, output, 6 bits: address from which instr_out was fetched.
REQ-013 Port instr_valid, output, 1 bit: instr_out/pc_out hold a live instruction.
REQ-014 Port halted, output, 1 bit: the block is in HALTED state.

Function
REQ-015 The block SHALL implement a three-state FSM with states IDLE, FETCH and HALTED.
REQ-016 In IDLE, the block SHALL transition to FETCH on start=1 and SHALL otherwise remain in IDLE with instr_valid=0.
REQ-017 In FETCH with stall=0 and branch_taken=0, the block SHALL, each cycle, load instr_out<=imem_data, pc_out<=PC and instr_valid<=1, and increment PC by 1.
REQ-018 PC arithmetic SHALL be 6-bit modulo, so that PC=63 increments to 0 with no flag raised.
REQ-019 In FETCH with branch_taken=1, the block SHALL load PC<=branch_target, set instr_valid<=0 for one bubble cycle, and leave instr_out/pc_out unchanged.
REQ-020 branch_taken SHALL take priority over stall, so a redirect is accepted even while stall=1.
REQ-021 In FETCH with stall=1 and branch_taken=0, PC, instr_out, pc_out and instr_valid SHALL all hold their values.
REQ-022 When an unstalled FETCH cycle sees imem_data==HALT_WORD, the block SHALL go to HALTED, set instr_valid<=0 without presenting the halt word, and hold PC at the halt address.
REQ-023 In HALTED, halted SHALL be 1 and branch_taken and stall SHALL be ignored.
REQ-024 In HALTED, start=1 SHALL load PC<=RESET_PC and return the FSM to FETCH.
REQ-025 start SHALL be ignored while in FETCH.
REQ-026 The fetch latency SHALL be one cycle: an instruction at address A appears on instr_out in the cycle after imem_addr==A in an unstalled, unredirected FETCH cycle.
REQ-027 imem_addr SHALL be driven combinationally from the PC register, with no other logic between them.

Reset
REQ-028 While rst_n=0, regardless of clk, the block SHALL force state=IDLE, PC=RESET_PC, instr_out=16'h0000, pc_out=6'd0, instr_valid=0 and halted=0.
REQ-029 Reset asserted mid-fetch or mid-stall SHALL discard the in-flight instruction, with instr_valid falling immediately.
REQ-030 After rst_n deasserts, no fetch SHALL occur until start is pulsed.

Verification
REQ-031 Scenario: reset, then start, with memory[0..2]=16'h4241, 16'hEC7F, 16'h4205 -> instr_out shows those words with pc_out 0, 1, 2 on three consecutive cycles, and instr_valid=1 from the first fetch.
REQ-032 Scenario: stall=1 for 3 cycles while instr_out=memory[1] -> instr_out, pc_out=1 and imem_addr=2 are unchanged for 3 cycles, and fetch resumes at address 2.
REQ-033 Scenario: branch_taken=1 with branch_target=3 while PC=8, with stall=1 in the same cycle -> next cycle instr_valid=0 and imem_addr=3; the cycle after, instr_out=memory[3] and pc_out=3.
REQ-034 Scenario: memory[5]=16'hFFFF -> after address 4 is presented, halted=1, instr_valid=0, and imem_addr holds 5; start then restarts fetch from address 0.
REQ-035 Scenario: branch to 62 with no halt word present -> pc_out sequence is 62, 63, 0, 1.
REQ-036 Scenario: rst_n pulsed low asynchronously mid-cycle during FETCH -> all outputs reach reset values before the next clk edge, and no fetch occurs until start.
